// File: rtl/apb_slv_mux.sv
// APB slave decoder/multiplexer: one-hot select, ready/error/read-data return path.
// Optional wait-cycle watchdog compiled in with APB_SLV_TIMEOUT_EN.
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_slv_mux #(
    parameter int NUM_SLV     = 4,
    parameter int SEL_LSB     = 12,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                               hclk,
    input  logic                               hreset_n,
    input  logic                               psel_en,
    input  logic [`PADDR_WIDTH-1:0]            paddr,
    input  logic                               penable,
    input  logic                               pwrite,
    output logic [NUM_SLV-1:0]                 psel_s,
    input  logic [NUM_SLV-1:0]                 pready_s,
    input  logic [NUM_SLV-1:0]                 pslverr_s,
    input  logic [NUM_SLV*`APB_DATA_WIDTH-1:0] prdata_s,
    output logic                               pready_x,
    output logic                               pslverr_x,
    output logic [`APB_DATA_WIDTH-1:0]         hrdata,
    output logic                               tout_pulse
);

    localparam int DW = `APB_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state_q, state_d, phase;
    logic [1:0]      idx, idx_q;
    logic            mapped, mapped_q;
    logic            complete, timeout;
    logic            sel_rdy, sel_err;
    logic [DW-1:0]   hrdata_q;
    logic [3:0]      rdy_arr, err_arr;
    logic [DW-1:0]   rdata_arr [4];
    logic            unused_ok;

    assign idx    = paddr[SEL_LSB+1:SEL_LSB];
    assign mapped = (int'(idx) < NUM_SLV);

    // Pad the per-slave returns to the full 2-bit index space; unmapped slots read as 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ret
            if (gi < NUM_SLV) begin : g_map
                assign rdy_arr[gi]   = pready_s[gi];
                assign err_arr[gi]   = pslverr_s[gi];
                assign rdata_arr[gi] = prdata_s[gi*DW +: DW];
            end else begin : g_unmap
                assign rdy_arr[gi]   = 1'b0;
                assign err_arr[gi]   = 1'b0;
                assign rdata_arr[gi] = '0;
            end
        end
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
            assign psel_s[gi] = hreset_n & psel_en & mapped & (idx == 2'(gi));
        end
    endgenerate

    // Bus phase of the current cycle, resolved combinationally from the registered
    // state so a SETUP straight after a completion is recognised without delay.
    always_comb begin
        phase = IDLE;
        if (hreset_n && psel_en) begin
            case (state_q)
                IDLE:    phase = penable ? IDLE : SETUP;
                SETUP:   phase = penable ? ACCESS : SETUP;
                ACCESS:  phase = ACCESS;
                default: phase = IDLE;
            endcase
        end
    end

    assign sel_rdy = rdy_arr[idx_q];
    assign sel_err = err_arr[idx_q];

`ifdef APB_SLV_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tout_q;

    assign timeout = (phase == ACCESS) && (cnt_q == 8'(TIMEOUT_CYC));

    always_comb begin
        cnt_d = cnt_q;
        if (phase == SETUP) begin
            cnt_d = 8'd0;
        end else if (phase == ACCESS && !sel_rdy) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            cnt_q  <= 8'd0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= timeout;
        end
    end

    assign tout_pulse = tout_q;
    assign unused_ok  = ^paddr;
`else
    assign timeout    = 1'b0;
    assign tout_pulse = 1'b0;
    assign unused_ok  = ^{paddr, 8'(TIMEOUT_CYC)};
`endif

    always_comb begin
        pready_x  = 1'b0;
        pslverr_x = 1'b0;
        if (phase == ACCESS) begin
            if (!mapped_q || timeout) begin
                pready_x  = 1'b1;
                pslverr_x = 1'b1;
            end else begin
                pready_x  = sel_rdy;
                pslverr_x = sel_err;
            end
        end
    end

    assign complete = (phase == ACCESS) && pready_x;

    always_comb begin
        state_d = phase;
        if (complete) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            mapped_q <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            // Routing for ACCESS is frozen at the end of SETUP.
            if (phase == SETUP) begin
                idx_q    <= idx;
                mapped_q <= mapped;
            end
            if (complete && !pwrite && !pslverr_x) begin
                hrdata_q <= rdata_arr[idx_q];
            end
        end
    end

    assign hrdata = hrdata_q;

endmodule

// File: tb/tb_apb_slv_mux.sv
// Randomised bench for apb_slv_mux: bridge + slave stimulus with a per-cycle behavioural model.
module tb_apb_slv_mux;
    localparam int NSLV = 3;
    localparam int TOC  = 4;
`ifdef APB_SLV_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hreset_n;
    logic        psel_en, penable, pwrite;
    logic [31:0] paddr;
    logic [2:0]  psel_s, pready_s, pslverr_s;
    logic [95:0] prdata_s;
    logic        pready_x, pslverr_x, tout_pulse;
    logic [31:0] hrdata;

    logic [2:0]  exp_psel;
    logic        exp_ready, exp_err, exp_tout;
    logic [31:0] exp_hrdata;
    logic [31:0] hr_pend;
    bit          hr_upd, tout_pend;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    apb_slv_mux #(.NUM_SLV(NSLV), .SEL_LSB(12), .TIMEOUT_CYC(TOC)) dut (
        .hclk(hclk), .hreset_n(hreset_n), .psel_en(psel_en), .paddr(paddr),
        .penable(penable), .pwrite(pwrite), .psel_s(psel_s), .pready_s(pready_s),
        .pslverr_s(pslverr_s), .prdata_s(prdata_s), .pready_x(pready_x),
        .pslverr_x(pslverr_x), .hrdata(hrdata), .tout_pulse(tout_pulse)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge hclk) begin
        check("psel_s", 32'(psel_s), 32'(exp_psel));
        check("pready_x", 32'(pready_x), 32'(exp_ready));
        check("pslverr_x", 32'(pslverr_x), 32'(exp_err));
        check("tout_pulse", 32'(tout_pulse), 32'(exp_tout));
        check("hrdata", hrdata, exp_hrdata);
    end

    // Advance one clock; registered effects of the finished cycle become visible.
    task automatic step();
        @(posedge hclk);
        #1;
        exp_tout  = tout_pend;
        tout_pend = 1'b0;
        if (hr_upd) exp_hrdata = hr_pend;
        hr_upd = 1'b0;
    endtask

    task automatic rand_bus();
        pready_s  = 3'($urandom);
        pslverr_s = 3'($urandom);
        prdata_s  = {$urandom, $urandom, $urandom};
    endtask

    task automatic set_idle();
        psel_en = 1'b0; penable = 1'b0;
        rand_bus();
        exp_psel = 3'b0; exp_ready = 1'b0; exp_err = 1'b0;
    endtask

    task automatic xfer(input int idx, input bit wr, input int waits, input bit err,
                        input logic [31:0] rd, input int max_acc,
                        output bit done, output int n_acc);
        bit mapped, sr, to;
        mapped = (idx < NSLV);
        done = 1'b0; n_acc = 0;
        psel_en = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = $urandom; paddr[13:12] = 2'(idx);
        rand_bus();
        exp_psel  = mapped ? 3'(1 << idx) : 3'b0;
        exp_ready = 1'b0; exp_err = 1'b0;
        step();
        for (int k = 1; k <= max_acc && !done; k++) begin
            penable = 1'b1;
            rand_bus();
            n_acc = k;
            to = 1'b0;
            if (mapped) begin
                sr = (k > waits);
                pready_s[idx] = sr;
                if (sr) pslverr_s[idx] = err;
                prdata_s[idx*32 +: 32] = rd;
                to = TO_EN && (k == TOC + 1);
                exp_ready = sr | to;
                exp_err   = to ? 1'b1 : pslverr_s[idx];
            end else begin
                exp_ready = 1'b1;
                exp_err   = 1'b1;
            end
            if (exp_ready) begin
                done = 1'b1;
                if (!wr && !exp_err) begin
                    hr_pend = rd;
                    hr_upd  = 1'b1;
                end
                tout_pend = to;
            end
            step();
        end
    endtask

    task automatic lit_hrdata(input string name, input logic [31:0] e);
        set_idle();
        @(negedge hclk);
        #1;
        check(name, hrdata, e);
        step();
    endtask

    initial begin
        bit done;
        int n;
        hreset_n = 1'b0; psel_en = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pready_s = '0; pslverr_s = '0; prdata_s = '0;
        exp_psel = '0; exp_ready = 1'b0; exp_err = 1'b0; exp_tout = 1'b0; exp_hrdata = '0;
        hr_pend = '0; hr_upd = 1'b0; tout_pend = 1'b0;
        for (int i = 0; i < 3; i++) step();
        hreset_n = 1'b1;
        set_idle(); step(); step();

        // Mapped read, zero wait
        xfer(2, 1'b0, 0, 1'b0, 32'hA5A5_0001, 20, done, n);
        check("read_cycles", 32'(n), 32'd1);
        lit_hrdata("read_hrdata", 32'hA5A5_0001);

        // Wait-state write
        xfer(1, 1'b1, 3, 1'b0, $urandom, 20, done, n);
        check("write_cycles", 32'(n), 32'd4);
        lit_hrdata("write_hrdata", 32'hA5A5_0001);

        // Unmapped access
        xfer(3, 1'b0, 0, 1'b0, $urandom, 20, done, n);
        check("unmapped_cycles", 32'(n), 32'd1);
        lit_hrdata("unmapped_hrdata", 32'hA5A5_0001);

        // Errored read
        xfer(0, 1'b0, 0, 1'b1, 32'hDEAD_0000, 20, done, n);
        lit_hrdata("errread_hrdata", 32'hA5A5_0001);

        // Stuck slave
        xfer(1, 1'b0, 1000, 1'b0, 32'h5555_5555, 100, done, n);
        check("stuck_cycles", 32'(n), TO_EN ? 32'd5 : 32'd100);
        set_idle();
        @(negedge hclk);
        #1;
        check("stuck_tout", 32'(tout_pulse), 32'(TO_EN));
        step();

        // Back-to-back reads
        xfer(0, 1'b0, 0, 1'b0, 32'hC0DE_0001, 20, done, n);
        xfer(2, 1'b0, 1, 1'b0, 32'hC0DE_0002, 20, done, n);
        lit_hrdata("b2b_hrdata", 32'hC0DE_0002);

        // Reset mid-ACCESS
        xfer(1, 1'b0, 1000, 1'b0, 32'h7777_7777, 2, done, n);
        penable = 1'b1; rand_bus(); pready_s[1] = 1'b0;
        hreset_n = 1'b0;
        exp_psel = '0; exp_ready = 1'b0; exp_err = 1'b0; exp_tout = 1'b0; exp_hrdata = '0;
        hr_upd = 1'b0; tout_pend = 1'b0;
        step();
        hreset_n = 1'b1;
        rand_bus();
        exp_psel = 3'b010; exp_ready = 1'b0; exp_err = 1'b0;
        step();
        set_idle(); step();
        xfer(1, 1'b0, 0, 1'b0, 32'h0BAD_F00D, 20, done, n);
        lit_hrdata("post_reset_hrdata", 32'h0BAD_F00D);

        // Randomised traffic
        for (int t = 0; t < 200; t++) begin
            xfer(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 6)),
                 ($urandom_range(0, 3) == 0), $urandom, 20, done, n);
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
                    set_idle(); step();
                end
            end
        end
        set_idle(); step(); step();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
